// File: rtl/alu_pkg.sv
// Shared opcode encodings and shifter kind codes for the execute-stage ALU.
package alu_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_AND   = 4'b0000;
   localparam alu_op_t ALU_OR    = 4'b0001;
   localparam alu_op_t ALU_ADD   = 4'b0010;
   localparam alu_op_t ALU_XOR   = 4'b0011;
   localparam alu_op_t ALU_SUB   = 4'b0100;
   localparam alu_op_t ALU_SLT   = 4'b0101;
   localparam alu_op_t ALU_SLTU  = 4'b0110;
   localparam alu_op_t ALU_NOR   = 4'b0111;
   localparam alu_op_t ALU_SLL   = 4'b1000;
   localparam alu_op_t ALU_SRL   = 4'b1001;
   localparam alu_op_t ALU_SRA   = 4'b1010;
   localparam alu_op_t ALU_PASSB = 4'b1011;
   localparam alu_op_t ALU_MUL   = 4'b1100;
   localparam alu_op_t ALU_ROTL  = 4'b1101;
   localparam alu_op_t ALU_ROTR  = 4'b1110;
   localparam alu_op_t ALU_RSVD  = 4'b1111;

   typedef logic [2:0] sh_kind_t;

   localparam sh_kind_t SH_SLL  = 3'd0;
   localparam sh_kind_t SH_SRL  = 3'd1;
   localparam sh_kind_t SH_SRA  = 3'd2;
   localparam sh_kind_t SH_ROTL = 3'd3;
   localparam sh_kind_t SH_ROTR = 3'd4;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit. Rotates use a doubled operand so that an
// amount of zero naturally returns the operand unchanged.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   sh,
   input  sh_kind_t         kind,
   output logic [WIDTH-1:0] y
);

   logic [2*WIDTH-1:0] w_rotl_dbl;
   logic [2*WIDTH-1:0] w_rotr_dbl;

   assign w_rotl_dbl = {a, a} << sh;
   assign w_rotr_dbl = {a, a} >> sh;

   // Select the shift flavour; unused kind codes pass the operand through.
   always_comb begin
      y = a;
      case (kind)
         SH_SLL:  y = a << sh;
         SH_SRL:  y = a >> sh;
         SH_SRA:  y = $unsigned($signed(a) >>> sh);
         SH_ROTL: y = w_rotl_dbl[2*WIDTH-1:WIDTH];
         SH_ROTR: y = w_rotr_dbl[WIDTH-1:0];
         default: y = a;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered integer ALU: combinational op mux followed by one output
// register stage for result and zero flag.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          aluop,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] w_add;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_mul;
   logic [WIDTH-1:0] w_shift;
   logic             w_lt_s;
   logic             w_lt_u;
   sh_kind_t         w_kind;
   logic [WIDTH-1:0] w_next;

   logic [WIDTH-1:0] r_result;
   logic             r_flag;

   assign w_add  = a + b;
   assign w_sub  = a - b;
   assign w_mul  = a * b;
   assign w_lt_s = $signed(a) < $signed(b);
   assign w_lt_u = a < b;

   // Map shift/rotate opcodes onto the shifter's kind encoding.
   always_comb begin
      w_kind = SH_SLL;
      case (aluop)
         ALU_SRL:  w_kind = SH_SRL;
         ALU_SRA:  w_kind = SH_SRA;
         ALU_ROTL: w_kind = SH_ROTL;
         ALU_ROTR: w_kind = SH_ROTR;
         default:  w_kind = SH_SLL;
      endcase
   end

   alu_shifter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_shifter (
      .a    (a),
      .sh   (b[SHW-1:0]),
      .kind (w_kind),
      .y    (w_shift)
   );

   // Operation select; the reserved code produces zero.
   always_comb begin
      w_next = '0;
      case (aluop)
         ALU_AND:   w_next = a & b;
         ALU_OR:    w_next = a | b;
         ALU_ADD:   w_next = w_add;
         ALU_XOR:   w_next = a ^ b;
         ALU_SUB:   w_next = w_sub;
         ALU_SLT:   w_next = {{(WIDTH-1){1'b0}}, w_lt_s};
         ALU_SLTU:  w_next = {{(WIDTH-1){1'b0}}, w_lt_u};
         ALU_NOR:   w_next = ~(a | b);
         ALU_SLL,
         ALU_SRL,
         ALU_SRA,
         ALU_ROTL,
         ALU_ROTR:  w_next = w_shift;
         ALU_PASSB: w_next = b;
         ALU_MUL:   w_next = w_mul;
         default:   w_next = '0;
      endcase
   end

   // Output register; reset wins over whatever op is presented on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_flag   <= 1'b0;
      end else begin
         r_result <= w_next;
         r_flag   <= (w_next == '0);
      end
   end

   assign result = r_result;
   assign flag   = r_flag;

endmodule

// File: tb/tb_alu.sv
// Bench for the registered ALU: a behavioural reference checked every cycle,
// plus directed vectors with hand-computed expected values.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  aluop;
   logic [31:0] result;
   logic        flag;

   int checks;
   int errors;

   alu #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .aluop  (aluop),
      .result (result),
      .flag   (flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: bit-by-bit shifting loops, offset-binary signed compare,
   // 64-bit product truncated.
   function automatic logic [31:0] model(input logic [3:0] op,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      logic [31:0] r;
      logic [63:0] p;
      int          sh;
      sh = int'(y % 32);
      r  = x;
      case (op)
         4'd0:  r = x & y;
         4'd1:  r = x | y;
         4'd2:  r = x + y;
         4'd3:  r = x ^ y;
         4'd4:  r = x - y;
         4'd5:  r = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd6:  r = (x < y) ? 32'd1 : 32'd0;
         4'd7:  r = ~(x | y);
         4'd8:  repeat (sh) r = {r[30:0], 1'b0};
         4'd9:  repeat (sh) r = {1'b0, r[31:1]};
         4'd10: repeat (sh) r = {r[31], r[31:1]};
         4'd11: r = y;
         4'd12: begin
            p = {32'd0, x} * {32'd0, y};
            r = p[31:0];
         end
         4'd13: repeat (sh) r = {r[30:0], r[31]};
         4'd14: repeat (sh) r = {r[0], r[31:1]};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Every edge: derive what the outputs must become, then compare just after.
   always @(posedge clk) begin
      logic [31:0] e_res;
      logic        e_flag;
      if (rst) begin
         e_res  = 32'd0;
         e_flag = 1'b0;
      end else begin
         e_res  = model(aluop, a, b);
         e_flag = (e_res == 32'd0);
      end
      #1;
      checks++;
      if (result !== e_res || flag !== e_flag) begin
         errors++;
         $display("FAIL model: result=%h flag=%b expected result=%h flag=%b", result, flag, e_res, e_flag);
      end
   end

   task automatic vec(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic ef, input string name);
      @(negedge clk);
      aluop = op;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      checks++;
      if (result !== er || flag !== ef) begin
         errors++;
         $display("FAIL %s: result=%h flag=%b expected result=%h flag=%b", name, result, flag, er, ef);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      a      = 32'hDEAD_BEEF;
      b      = 32'h1234_5678;
      aluop  = 4'd2;

      // Reset held two cycles with arbitrary inputs
      repeat (2) begin
         @(negedge clk);
         a     = $urandom;
         b     = $urandom;
         aluop = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      #1;
      checks++;
      if (result !== 32'd0 || flag !== 1'b0) begin
         errors++;
         $display("FAIL reset: result=%h flag=%b expected result=0 flag=0", result, flag);
      end
      @(negedge clk);
      rst = 1'b0;
      vec(4'd2, 32'd5, 32'd3, 32'd8, 1'b0, "add_after_reset");

      // Base operands
      vec(4'd0,  32'h2000, 32'h17FB, 32'h0,        1'b1, "base_and");
      vec(4'd2,  32'h2000, 32'h17FB, 32'h37FB,     1'b0, "base_add");
      vec(4'd4,  32'h2000, 32'h17FB, 32'h805,      1'b0, "base_sub");
      vec(4'd5,  32'h2000, 32'h17FB, 32'h0,        1'b1, "base_slt");
      vec(4'd6,  32'h2000, 32'h17FB, 32'h0,        1'b1, "base_sltu");
      vec(4'd7,  32'h2000, 32'h17FB, 32'hFFFFC804, 1'b0, "base_nor");
      vec(4'd10, 32'h2000, 32'h17FB, 32'h0,        1'b1, "base_sra27");

      // Wrap and compare
      vec(4'd2, 32'hFFFFFFFF, 32'd1, 32'h0,        1'b1, "add_wrap");
      vec(4'd4, 32'h0,        32'd1, 32'hFFFFFFFF, 1'b0, "sub_wrap");
      vec(4'd5, 32'h80000000, 32'd1, 32'd1,        1'b0, "slt_neg");
      vec(4'd6, 32'h80000000, 32'd1, 32'd0,        1'b1, "sltu_big");

      // Shifts and rotates
      vec(4'd8,  32'h80000001, 32'd4, 32'h00000010, 1'b0, "sll4");
      vec(4'd9,  32'h80000001, 32'd4, 32'h08000000, 1'b0, "srl4");
      vec(4'd10, 32'h80000001, 32'd4, 32'hF8000000, 1'b0, "sra4");
      vec(4'd13, 32'h80000001, 32'd4, 32'h00000018, 1'b0, "rotl4");
      vec(4'd14, 32'h80000001, 32'd4, 32'h18000000, 1'b0, "rotr4");
      vec(4'd8,  32'h80000001, 32'h20, 32'h80000001, 1'b0, "sll0");
      vec(4'd9,  32'h80000001, 32'h20, 32'h80000001, 1'b0, "srl0");
      vec(4'd10, 32'h80000001, 32'h20, 32'h80000001, 1'b0, "sra0");
      vec(4'd13, 32'h80000001, 32'h20, 32'h80000001, 1'b0, "rotl0");
      vec(4'd14, 32'h80000001, 32'h20, 32'h80000001, 1'b0, "rotr0");
      vec(4'd13, 32'h80000001, 32'hFFFFFFE1, 32'h00000003, 1'b0, "rotl_upper_ignored");

      // Multiply, pass, reserved
      vec(4'd12, 32'h10000, 32'h10000, 32'h0,    1'b1, "mul_wrap");
      vec(4'd12, 32'd7,     32'd6,     32'd42,   1'b0, "mul_small");
      vec(4'd11, 32'hABCD,  32'h1234,  32'h1234, 1'b0, "passb");
      vec(4'd3,  32'hF0F0,  32'h0FF0,  32'hFF00, 1'b0, "xor");
      vec(4'd1,  32'hF000,  32'h000F,  32'hF00F, 1'b0, "or");
      vec(4'd15, 32'h1234,  32'h5678,  32'h0,    1'b1, "reserved");

      // Back-to-back random stream, checked by the reference every cycle
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         a     = $urandom;
         b     = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         aluop = 4'(i % 16);
      end

      // Mid-stream reset discards the op on that edge
      @(negedge clk);
      rst   = 1'b1;
      aluop = 4'd2;
      a     = 32'd5;
      b     = 32'd3;
      @(posedge clk);
      #1;
      checks++;
      if (result !== 32'd0 || flag !== 1'b0) begin
         errors++;
         $display("FAIL midstream_reset: result=%h flag=%b expected result=0 flag=0", result, flag);
      end
      @(negedge clk);
      rst = 1'b0;
      vec(4'd4, 32'd10, 32'd3, 32'd7, 1'b0, "sub_after_midreset");
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         a     = $urandom;
         b     = $urandom;
         aluop = 4'($urandom_range(0, 15));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
